// File: rtl/rx_sample_loader_pkg.sv
// Shared types and defaults for the UART sample loader and its bit receiver.
package rx_sample_loader_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int NUM_SAMPLES_DEFAULT  = 16384;
    localparam int ADDR_W               = 14;
    localparam int DATA_W               = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/rx_sample_loader_if.sv
// Sample RAM write port: the loader drives it, the RAM consumes it.
interface rx_sample_loader_if;
    import rx_sample_loader_pkg::*;

    logic              ram_write_en;
    logic [ADDR_W-1:0] ram_write_addr;
    logic [DATA_W-1:0] ram_data_in;

    modport master (output ram_write_en, output ram_write_addr, output ram_data_in);
    modport slave  (input  ram_write_en, input  ram_write_addr, input  ram_data_in);

endinterface

// File: rtl/rx_sample_loader_uart_rx.sv
// 8N1 UART byte receiver with a 2-flop synchroniser and mid-bit sampling.
module uart_rx
    import rx_sample_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_out,
    output logic       frame_err_pulse
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             r_syncMeta;
    logic             r_sync;
    logic             r_syncPrev;
    rx_state_t        r_state;
    rx_state_t        w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bitIdx;
    logic [7:0]       r_shift;
    logic             w_fall;
    logic             w_halfDone;
    logic             w_fullDone;

    assign w_fall     = r_syncPrev & ~r_sync;
    assign w_halfDone = (r_cnt == HALF_LAST);
    assign w_fullDone = (r_cnt == FULL_LAST);

    // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_syncMeta <= 1'b1;
            r_sync     <= 1'b1;
            r_syncPrev <= 1'b1;
        end else begin
            r_syncMeta <= rxd;
            r_sync     <= r_syncMeta;
            r_syncPrev <= r_sync;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RX_IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            RX_IDLE:  if (w_fall) w_nextState = RX_START;
            RX_START: if (w_halfDone) w_nextState = r_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_fullDone && (r_bitIdx == 3'd7)) w_nextState = RX_STOP;
            RX_STOP:  if (w_fullDone) w_nextState = RX_IDLE;
            default:  w_nextState = RX_IDLE;
        endcase
    end

    // The bit timer restarts on every state change and at each data-bit centre.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
        end else begin
            if ((r_state == RX_IDLE) || (w_nextState != r_state) ||
                ((r_state == RX_DATA) && w_fullDone))
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (r_state == RX_IDLE)
                r_bitIdx <= '0;
            else if ((r_state == RX_DATA) && w_fullDone) begin
                r_shift  <= {r_sync, r_shift[7:1]};
                r_bitIdx <= r_bitIdx + 1'b1;
            end
        end
    end

    always_comb begin
        byte_valid      = (r_state == RX_STOP) && w_fullDone && r_sync;
        frame_err_pulse = (r_state == RX_STOP) && w_fullDone && !r_sync;
        byte_out        = r_shift;
    end

endmodule

// File: rtl/rx_sample_loader.sv
// Packs pairs of received UART bytes into 16-bit samples and writes them to
// sequential RAM addresses until NUM_SAMPLES have been captured.
module rx_sample_loader
    import rx_sample_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int NUM_SAMPLES  = NUM_SAMPLES_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       rx_start,
    input  logic                       rx_stop,
    input  logic                       com_UART_RXD,
    rx_sample_loader_if.master         ram,
    output logic                       busy,
    output logic                       done,
    output logic                       frame_err
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);

    loader_state_t     r_state;
    loader_state_t     w_nextState;
    logic              w_byteValid;
    logic [7:0]        w_byte;
    logic              w_frameErrPulse;
    logic              w_stopLoad;
    logic              w_restart;
    logic              w_takeHigh;
    logic              w_issueWrite;
    logic [ADDR_W-1:0] r_index;
    logic              r_phase;
    logic [7:0]        r_high;
    logic              r_wrEn;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [DATA_W-1:0] r_wrData;
    logic              r_frameErr;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk             (clk),
        .reset           (reset),
        .rxd             (com_UART_RXD),
        .byte_valid      (w_byteValid),
        .byte_out        (w_byte),
        .frame_err_pulse (w_frameErrPulse)
    );

    // A stop request during a capture outranks a simultaneous restart.
    assign w_stopLoad   = (r_state == LOAD) && rx_stop;
    assign w_restart    = rx_start && !w_stopLoad;
    assign w_takeHigh   = (r_state == LOAD) && !rx_stop && !rx_start && w_byteValid && !r_phase;
    assign w_issueWrite = (r_state == LOAD) && !rx_stop && !rx_start && w_byteValid && r_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (rx_start) w_nextState = LOAD;
            LOAD: begin
                if (rx_stop)                              w_nextState = IDLE;
                else if (rx_start)                        w_nextState = LOAD;
                else if (r_wrEn && (r_index == LAST_IDX)) w_nextState = DONE;
            end
            DONE: if (rx_start) w_nextState = LOAD;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == LOAD);
        done      = (r_state == DONE);
        frame_err = r_frameErr;
    end

    // The index advances in the write cycle itself and saturates at the last address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_index    <= '0;
            r_phase    <= 1'b0;
            r_high     <= '0;
            r_wrEn     <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_frameErr <= 1'b0;
        end else begin
            r_wrEn <= w_issueWrite;
            if (w_issueWrite) begin
                r_wrAddr <= r_index;
                r_wrData <= {r_high, w_byte};
            end
            if (w_restart) begin
                r_index    <= '0;
                r_phase    <= 1'b0;
                r_frameErr <= 1'b0;
            end else begin
                if (w_frameErrPulse)
                    r_frameErr <= 1'b1;
                if (w_stopLoad || w_issueWrite)
                    r_phase <= 1'b0;
                else if (w_takeHigh) begin
                    r_high  <= w_byte;
                    r_phase <= 1'b1;
                end
                if (r_wrEn && (r_index != LAST_IDX))
                    r_index <= r_index + 1'b1;
            end
        end
    end

    assign ram.ram_write_en   = r_wrEn;
    assign ram.ram_write_addr = r_wrAddr;
    assign ram.ram_data_in    = r_wrData;

endmodule

// File: tb/tb_rx_sample_loader.sv
// Directed bench for rx_sample_loader: a transaction-level model of the capture
// rules predicts every RAM write and the busy/done/frame_err flags.
module tb_rx_sample_loader;

    localparam int CLKS  = 16;
    localparam int NSAMP = 4;

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic rx_start;
    logic rx_stop;
    logic rxd;
    logic busy;
    logic done;
    logic frame_err;

    rx_sample_loader_if ramBus ();

    rx_sample_loader #(.CLKS_PER_BIT(CLKS), .NUM_SAMPLES(NSAMP)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_start     (rx_start),
        .rx_stop      (rx_stop),
        .com_UART_RXD (rxd),
        .ram          (ramBus),
        .busy         (busy),
        .done         (done),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    bit   mLoading;
    bit   mDone;
    bit   mFrameErr;
    bit   mHaveHigh;
    int   mIndex;
    logic [7:0] mHigh;
    wr_t  expWrites[$];

    bit          quiet = 1'b0;
    int          wrCount = 0;
    logic [13:0] lastAddr = '0;
    logic [15:0] lastData = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic void modelReset();
        mLoading  = 1'b0;
        mDone     = 1'b0;
        mFrameErr = 1'b0;
        mHaveHigh = 1'b0;
        mIndex    = 0;
        mHigh     = '0;
        expWrites.delete();
    endfunction

    function automatic void modelControl(input bit start, input bit stop);
        if (mLoading && stop) begin
            mLoading  = 1'b0;
            mHaveHigh = 1'b0;
        end else if (start) begin
            mLoading  = 1'b1;
            mDone     = 1'b0;
            mFrameErr = 1'b0;
            mHaveHigh = 1'b0;
            mIndex    = 0;
        end
    endfunction

    function automatic void modelByte(input logic [7:0] b, input bit stopOk);
        wr_t w;
        if (!stopOk) mFrameErr = 1'b1;
        else if (mLoading) begin
            if (!mHaveHigh) begin
                mHigh     = b;
                mHaveHigh = 1'b1;
            end else begin
                w.addr = 14'(mIndex);
                w.data = {mHigh, b};
                expWrites.push_back(w);
                mHaveHigh = 1'b0;
                if (mIndex == NSAMP - 1) begin
                    mLoading = 1'b0;
                    mDone    = 1'b1;
                end else mIndex++;
            end
        end
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit start, input bit stop);
        rx_start = start;
        rx_stop  = stop;
        waitCycles(1);
        rx_start = 1'b0;
        rx_stop  = 1'b0;
        modelControl(start, stop);
        waitCycles(1);
    endtask

    // The model takes the byte at the start of its stop bit; flags are not compared until the stop bit ends.
    task automatic sendByte(input logic [7:0] b, input bit stopBit);
        rxd = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            waitCycles(CLKS);
        end
        rxd   = stopBit;
        quiet = 1'b1;
        modelByte(b, stopBit);
        waitCycles(CLKS);
        quiet = 1'b0;
        rxd   = 1'b1;
        waitCycles(CLKS);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wrEn"},  32'(ramBus.ram_write_en),   32'h0);
        checkOutput({tag, "_addr"},  32'(ramBus.ram_write_addr), 32'h0);
        checkOutput({tag, "_data"},  32'(ramBus.ram_data_in),    32'h0);
        checkOutput({tag, "_busy"},  32'(busy),                  32'h0);
        checkOutput({tag, "_done"},  32'(done),                  32'h0);
        checkOutput({tag, "_ferr"},  32'(frame_err),             32'h0);
    endtask

    always @(negedge clk) begin
        if (ramBus.ram_write_en === 1'b1) begin
            wrCount++;
            lastAddr = ramBus.ram_write_addr;
            lastData = ramBus.ram_data_in;
            checkOutput("writeExpected", 32'(ramBus.ram_write_en), 32'(expWrites.size() > 0));
            if (expWrites.size() > 0) begin
                wr_t e;
                e = expWrites.pop_front();
                checkOutput("writeAddr", 32'(ramBus.ram_write_addr), 32'(e.addr));
                checkOutput("writeData", 32'(ramBus.ram_data_in),    32'(e.data));
            end
        end
        if (!quiet) begin
            checkOutput("busy",     32'(busy),      32'(mLoading));
            checkOutput("done",     32'(done),      32'(mDone));
            checkOutput("frameErr", 32'(frame_err), 32'(mFrameErr));
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int wrBase;
        reset    = 1'b1;
        rxd      = 1'b1;
        rx_start = 1'b0;
        rx_stop  = 1'b0;
        modelReset();
        waitCycles(3);
        checkAllZero("reset");
        reset = 1'b0;
        waitCycles(4);

        // First sample lands at address 0.
        applyStimulus(1'b1, 1'b0);
        sendByte(8'h12, 1'b1);
        sendByte(8'h34, 1'b1);
        checkOutput("t1WrCount", 32'(wrCount), 32'd1);
        checkOutput("t1Addr",    32'(lastAddr), 32'h0);
        checkOutput("t1Data",    32'(lastData), 32'h1234);
        checkOutput("t1Busy",    32'(busy),     32'h1);

        // Full capture of NSAMP samples, then bytes in DONE are ignored.
        applyStimulus(1'b1, 1'b0);
        wrBase = wrCount;
        for (int i = 1; i <= 8; i++) sendByte(8'(i), 1'b1);
        checkOutput("t2WrCount", 32'(wrCount - wrBase), 32'd4);
        checkOutput("t2LastAddr", 32'(lastAddr), 32'h3);
        checkOutput("t2LastData", 32'(lastData), 32'h0708);
        checkOutput("t2Done", 32'(done), 32'h1);
        checkOutput("t2Busy", 32'(busy), 32'h0);
        sendByte(8'hAA, 1'b1);
        sendByte(8'hBB, 1'b1);
        checkOutput("t2NoExtraWrite", 32'(wrCount - wrBase), 32'd4);
        checkOutput("t2DoneHeld", 32'(done), 32'h1);

        applyStimulus(1'b1, 1'b1);
        checkOutput("bothInDoneBusy", 32'(busy), 32'h1);
        checkOutput("bothInDoneDone", 32'(done), 32'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("bothInLoadBusy", 32'(busy), 32'h0);

        // Short low glitch must be rejected at the half-bit re-check.
        applyStimulus(1'b1, 1'b0);
        wrBase = wrCount;
        rxd = 1'b0;
        waitCycles(5);
        rxd = 1'b1;
        waitCycles(3 * CLKS);
        checkOutput("t3NoWrite", 32'(wrCount - wrBase), 32'd0);
        checkOutput("t3FrameErr", 32'(frame_err), 32'h0);
        checkOutput("t3Busy", 32'(busy), 32'h1);
        sendByte(8'h5A, 1'b1);
        sendByte(8'hA5, 1'b1);
        checkOutput("t3AfterData", 32'(lastData), 32'h5AA5);

        // Bad stop bit sets frame_err and leaves the byte phase alone.
        applyStimulus(1'b1, 1'b0);
        wrBase = wrCount;
        sendByte(8'hAB, 1'b0);
        checkOutput("t4FrameErrSet", 32'(frame_err), 32'h1);
        sendByte(8'hCD, 1'b1);
        sendByte(8'hEF, 1'b1);
        checkOutput("t4WrCount", 32'(wrCount - wrBase), 32'd1);
        checkOutput("t4Addr", 32'(lastAddr), 32'h0);
        checkOutput("t4Data", 32'(lastData), 32'hCDEF);
        checkOutput("t4FrameErrHeld", 32'(frame_err), 32'h1);

        // rx_stop drops the pending high byte; bytes in IDLE do not write.
        applyStimulus(1'b1, 1'b0);
        sendByte(8'h11, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t5StopBusy", 32'(busy), 32'h0);
        wrBase = wrCount;
        sendByte(8'h22, 1'b1);
        sendByte(8'h33, 1'b1);
        checkOutput("t5IdleNoWrite", 32'(wrCount - wrBase), 32'd0);
        applyStimulus(1'b1, 1'b0);
        sendByte(8'h00, 1'b1);
        sendByte(8'h01, 1'b1);
        checkOutput("t5WrCount", 32'(wrCount - wrBase), 32'd1);
        checkOutput("t5Addr", 32'(lastAddr), 32'h0);
        checkOutput("t5Data", 32'(lastData), 32'h0001);

        // Reset in the middle of the 5th data bit of a partial sample.
        applyStimulus(1'b1, 1'b0);
        sendByte(8'h55, 1'b1);
        sendByte(8'hAA, 1'b1);
        sendByte(8'h77, 1'b1);
        rxd = 1'b0;
        waitCycles(CLKS);
        for (int i = 0; i < 4; i++) begin
            rxd = 1'(8'h8C >> i);
            waitCycles(CLKS);
        end
        rxd = 1'b0;
        waitCycles(CLKS / 2);
        reset = 1'b1;
        modelReset();
        #1;
        checkAllZero("midReset");
        waitCycles(2);
        rxd   = 1'b1;
        reset = 1'b0;
        waitCycles(4);
        applyStimulus(1'b1, 1'b0);
        wrBase = wrCount;
        sendByte(8'h9A, 1'b1);
        sendByte(8'hBC, 1'b1);
        checkOutput("t6WrCount", 32'(wrCount - wrBase), 32'd1);
        checkOutput("t6Addr", 32'(lastAddr), 32'h0);
        checkOutput("t6Data", 32'(lastData), 32'h9ABC);

        waitCycles(4);
        checkOutput("pendingWrites", 32'(expWrites.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
